// File: rtl/sha1_timer_cycle_meter_if.sv
// Avalon-MM bus between the SHA1 cycle meter (master) and the interval timer register port (slave).
interface sha1_timer_cycle_meter_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata
  );
endinterface

// File: rtl/sha1_timer_cycle_meter.sv
// Drives the interval timer over Avalon-MM to measure SHA1 cycle counts without CPU involvement.
// Optional feature macro SHA1_CYCLE_METER_ACCUM_EN adds a saturating accumulator and run counter.
module sha1_timer_cycle_meter #(
  parameter logic [31:0] PERIOD     = 32'hFFFF_FFFF,
  parameter bit          IRQ_ENABLE = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_req,
  input  logic                     stop_req,
  input  logic                     timeout_pulse,
  sha1_timer_cycle_meter_if.master avm,
  output logic                     busy,
  output logic [31:0]              elapsed,
  output logic                     overflow,
  output logic                     result_valid
`ifdef SHA1_CYCLE_METER_ACCUM_EN
  ,
  input  logic                     accum_clr,
  output logic [47:0]              accum,
  output logic [15:0]              runs
`endif
);

  typedef enum logic [3:0] {
    IDLE,
    WR_PL,
    WR_PH,
    SETTLE,
    WR_GO,
    RUN,
    WR_SNAP,
    RD_L,
    RD_H,
    CAP_H,
    WR_STOP,
    WR_CLR,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        stop_pend;
  logic        overflow_flag;
  logic [31:0] snap;

  logic [2:0]  bus_address;
  logic        bus_chipselect;
  logic        bus_write_n;
  logic [15:0] bus_writedata;

  assign avm.avm_address    = bus_address;
  assign avm.avm_chipselect = bus_chipselect;
  assign avm.avm_write_n    = bus_write_n;
  assign avm.avm_writedata  = bus_writedata;
  assign busy               = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus signals decode straight from the state register so an async reset idles the bus at once.
  always_comb begin
    state_next     = state;
    bus_address    = 3'd0;
    bus_chipselect = 1'b0;
    bus_write_n    = 1'b1;
    bus_writedata  = 16'h0000;
    case (state)
      IDLE: begin
        if (start_req) state_next = WR_PL;
      end
      WR_PL: begin
        bus_address    = 3'd2;
        bus_chipselect = 1'b1;
        bus_write_n    = 1'b0;
        bus_writedata  = PERIOD[15:0];
        state_next     = WR_PH;
      end
      WR_PH: begin
        bus_address    = 3'd3;
        bus_chipselect = 1'b1;
        bus_write_n    = 1'b0;
        bus_writedata  = PERIOD[31:16];
        state_next     = SETTLE;
      end
      SETTLE: begin
        state_next = WR_GO;
      end
      WR_GO: begin
        bus_address    = 3'd1;
        bus_chipselect = 1'b1;
        bus_write_n    = 1'b0;
        bus_writedata  = {12'h000, 3'b010, IRQ_ENABLE};
        state_next     = RUN;
      end
      RUN: begin
        if (stop_req || stop_pend) state_next = WR_SNAP;
      end
      WR_SNAP: begin
        bus_address    = 3'd4;
        bus_chipselect = 1'b1;
        bus_write_n    = 1'b0;
        state_next     = RD_L;
      end
      RD_L: begin
        bus_address    = 3'd4;
        bus_chipselect = 1'b1;
        state_next     = RD_H;
      end
      RD_H: begin
        bus_address    = 3'd5;
        bus_chipselect = 1'b1;
        state_next     = CAP_H;
      end
      CAP_H: begin
        state_next = WR_STOP;
      end
      WR_STOP: begin
        bus_address    = 3'd1;
        bus_chipselect = 1'b1;
        bus_write_n    = 1'b0;
        bus_writedata  = 16'h0008;
        state_next     = WR_CLR;
      end
      WR_CLR: begin
        bus_address    = 3'd0;
        bus_chipselect = 1'b1;
        bus_write_n    = 1'b0;
        state_next     = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A stop arriving while the timer is still being programmed is remembered so RUN exits immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stop_pend     <= 1'b0;
      overflow_flag <= 1'b0;
    end else if (state == IDLE) begin
      if (start_req) begin
        stop_pend     <= 1'b0;
        overflow_flag <= 1'b0;
      end
    end else begin
      if (stop_req && (state inside {WR_PL, WR_PH, SETTLE, WR_GO})) stop_pend <= 1'b1;
      if (timeout_pulse && (state inside {WR_GO, RUN, WR_SNAP, RD_L, RD_H, CAP_H, WR_STOP, WR_CLR}))
        overflow_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap <= 32'h0000_0000;
    end else if (state == RD_H) begin
      snap[15:0] <= avm.avm_readdata;
    end else if (state == CAP_H) begin
      snap[31:16] <= avm.avm_readdata;
    end
  end

  // Results load on the edge into DONE so elapsed/overflow are already valid while result_valid is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elapsed      <= 32'h0000_0000;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else if (state == WR_CLR) begin
      result_valid <= 1'b1;
      if (overflow_flag || timeout_pulse) begin
        elapsed  <= PERIOD;
        overflow <= 1'b1;
      end else begin
        elapsed  <= PERIOD - snap;
        overflow <= 1'b0;
      end
    end else begin
      result_valid <= 1'b0;
    end
  end

`ifdef SHA1_CYCLE_METER_ACCUM_EN
  logic [48:0] accum_sum;

  assign accum_sum = {1'b0, accum} + {17'h0_0000, elapsed};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accum <= 48'h0;
      runs  <= 16'h0;
    end else if (accum_clr) begin
      accum <= 48'h0;
      runs  <= 16'h0;
    end else if (result_valid) begin
      accum <= accum_sum[48] ? {48{1'b1}} : accum_sum[47:0];
      if (runs != 16'hFFFF) runs <= runs + 16'h1;
    end
  end
`endif

endmodule

// File: tb/tb_sha1_timer_cycle_meter.sv
// Scoreboard bench for sha1_timer_cycle_meter: expected bus accesses and results are queued
// when stimulus is driven and checked against the DUT at each falling clock edge.
module tb_sha1_timer_cycle_meter;
  localparam logic [31:0] PERIOD = 32'd1000;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic        wr_n;
    logic [15:0] data;
  } bus_t;

  typedef struct {
    int          cyc;
    logic [31:0] elapsed;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_req = 1'b0;
  logic        stop_req = 1'b0;
  logic        timeout_pulse = 1'b0;
  logic        busy;
  logic [31:0] elapsed;
  logic        overflow;
  logic        result_valid;
`ifdef SHA1_CYCLE_METER_ACCUM_EN
  logic        accum_clr = 1'b0;
  logic [47:0] accum;
  logic [15:0] runs;
`endif

  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  logic [31:0] snap_val = 32'h0;
  bus_t        bus_q[$];
  res_t        res_q[$];

  sha1_timer_cycle_meter_if avm ();

  sha1_timer_cycle_meter #(
    .PERIOD     (PERIOD),
    .IRQ_ENABLE (1'b0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_req     (start_req),
    .stop_req      (stop_req),
    .timeout_pulse (timeout_pulse),
    .avm           (avm.master),
    .busy          (busy),
    .elapsed       (elapsed),
    .overflow      (overflow),
    .result_valid  (result_valid)
`ifdef SHA1_CYCLE_METER_ACCUM_EN
    ,
    .accum_clr     (accum_clr),
    .accum         (accum),
    .runs          (runs)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Timer register port model: registered read data, snapshot halves at addresses 4 and 5.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      avm.avm_readdata <= 16'h0;
    end else if (avm.avm_chipselect && avm.avm_write_n) begin
      if (avm.avm_address == 3'd4)      avm.avm_readdata <= snap_val[15:0];
      else if (avm.avm_address == 3'd5) avm.avm_readdata <= snap_val[31:16];
      else                              avm.avm_readdata <= 16'h0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    else
      passed++;
  endtask

  // Monitor: every bus access and every result must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (avm.avm_chipselect) begin
        if (bus_q.size() == 0) begin
          checkOutput("bus_unexpected", {1'b1, avm.avm_address, avm.avm_write_n, avm.avm_writedata}, 64'h0);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          checkOutput("bus_cycle", cyc, e.cyc);
          checkOutput("bus_op", {avm.avm_address, avm.avm_write_n, avm.avm_writedata},
                      {e.addr, e.wr_n, e.data});
        end
      end else begin
        checkOutput("bus_idle", {avm.avm_address, avm.avm_write_n, avm.avm_writedata},
                    {3'd0, 1'b1, 16'h0000});
      end
      if (result_valid) begin
        if (res_q.size() == 0) begin
          checkOutput("result_unexpected", {1'b1, elapsed}, 64'h0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          checkOutput("result_cycle", cyc, r.cyc);
          checkOutput("elapsed", elapsed, r.elapsed);
          checkOutput("overflow", overflow, r.ovf);
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one-cycle pulses starting at the current falling edge.
  task automatic applyStimulus(input logic s, input logic p, input logic t);
    start_req     = s;
    stop_req      = p;
    timeout_pulse = t;
    @(negedge clk);
    start_req     = 1'b0;
    stop_req      = 1'b0;
    timeout_pulse = 1'b0;
  endtask

  task automatic pushStart(input int c);
    bus_q.push_back('{c + 1, 3'd2, 1'b0, PERIOD[15:0]});
    bus_q.push_back('{c + 2, 3'd3, 1'b0, PERIOD[31:16]});
    bus_q.push_back('{c + 4, 3'd1, 1'b0, 16'h0004});
  endtask

  // s is the RUN cycle in which the stop takes effect.
  task automatic pushStop(input int s, input logic [31:0] snap, input logic ovf);
    snap_val = snap;
    bus_q.push_back('{s + 1, 3'd4, 1'b0, 16'h0000});
    bus_q.push_back('{s + 2, 3'd4, 1'b1, 16'h0000});
    bus_q.push_back('{s + 3, 3'd5, 1'b1, 16'h0000});
    bus_q.push_back('{s + 5, 3'd1, 1'b0, 16'h0008});
    bus_q.push_back('{s + 6, 3'd0, 1'b0, 16'h0000});
    res_q.push_back('{s + 7, ovf ? PERIOD : PERIOD - snap, ovf});
  endtask

  task automatic doRun(input logic [31:0] snap);
    int c;
    int s;
    c = cyc;
    pushStart(c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(4);
    checkOutput("busy_run", busy, 1'b1);
    waitCycles(1);
    s = cyc;
    pushStop(s, snap, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(9);
    checkOutput("busy_after", busy, 1'b0);
  endtask

  initial begin
    int c;
    int s;
    waitCycles(3);
    checkOutput("rst_chipselect", avm.avm_chipselect, 1'b0);
    checkOutput("rst_write_n", avm.avm_write_n, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_elapsed", elapsed, 32'h0);
    checkOutput("rst_overflow", overflow, 1'b0);
    checkOutput("rst_result_valid", result_valid, 1'b0);
    reset = 1'b0;
    waitCycles(2);

    $display("[TB] basic measurement, snapshot 900");
    doRun(32'h0000_0384);

    $display("[TB] stop in IDLE is ignored");
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("idle_stop_busy", busy, 1'b0);

    $display("[TB] start and stop together: stop dropped");
    c = cyc;
    pushStart(c);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitCycles(7);
    s = cyc;
    pushStop(s, 32'h0000_03E7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(9);

    $display("[TB] timeout in RUN saturates");
    c = cyc;
    pushStart(c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(2);
    s = cyc;
    pushStop(s, 32'h0000_0200, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(9);

    $display("[TB] timeout in CAP_H saturates");
    c = cyc;
    pushStart(c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(5);
    s = cyc;
    pushStop(s, 32'h0000_0010, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitCycles(6);

    $display("[TB] timeout in IDLE does not carry into next run");
    applyStimulus(1'b0, 1'b0, 1'b1);
    doRun(32'h0000_0064);

    $display("[TB] stop during WR_PH, second start while busy, wrapping subtraction");
    c = cyc;
    pushStart(c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(1);
    pushStop(c + 5, 32'h0001_0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(6);
    checkOutput("second_start_ignored_busy", busy, 1'b0);

    $display("[TB] reset during RD_H");
    c = cyc;
    pushStart(c);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(5);
    s = cyc;
    pushStop(s, 32'h0000_0100, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(2);
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid_chipselect", avm.avm_chipselect, 1'b0);
    checkOutput("rst_mid_write_n", avm.avm_write_n, 1'b1);
    checkOutput("rst_mid_address", avm.avm_address, 3'd0);
    checkOutput("rst_mid_busy", busy, 1'b0);
    checkOutput("rst_mid_elapsed", elapsed, 32'h0);
    bus_q.delete();
    res_q.delete();
    @(negedge clk);
    reset = 1'b0;
    waitCycles(10);
    checkOutput("post_rst_busy", busy, 1'b0);
    doRun(32'h0000_02BC);

`ifdef SHA1_CYCLE_METER_ACCUM_EN
    $display("[TB] accumulator");
    accum_clr = 1'b1;
    @(negedge clk);
    accum_clr = 1'b0;
    checkOutput("accum_cleared", accum, 48'h0);
    checkOutput("runs_cleared", runs, 16'h0);
    doRun(32'h0000_0384);
    doRun(32'h0000_0320);
    checkOutput("accum_sum", accum, 48'd300);
    checkOutput("runs_count", runs, 16'd2);
`endif

    waitCycles(3);
    checkOutput("bus_queue_drained", bus_q.size(), 0);
    checkOutput("result_queue_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
